shift_unit: RTL and testbench

Parametrised, multi-cycle shifter for the execute stage: successor to the fixed left-shift-by-2 used for branch offsets. It performs logical left, logical right, arithmetic right and, optionally, rotate-left by a variable amount. Each clock it shifts by up to STEP bits, trading latency for area. It uses a start/busy/done handshake so the pipeline control can stall EX while a shift is in flight.

---
 rtl/shift_pkg.sv | 17 +
 rtl/shift_step.sv | 37 +++
 rtl/shift_unit.sv | 85 ++++++++
 tb/tb_shift_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle execute-stage shifter.
package shift_pkg;

   typedef enum logic [1:0] {
      SH_SLL = 2'b00,
      SH_SRL = 2'b01,
      SH_SRA = 2'b10,
      SH_ROL = 2'b11
   } shift_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } shift_state_e;

endpackage

// File: rtl/shift_step.sv
// Single combinational shift stage: shifts value by k (0..STEP) bits.
// Build option: SHIFT_ROTATE_EN adds the rotate-left datapath; without it
// the ROL encoding falls through to SLL.
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 4,
   localparam int KW   = $clog2(STEP + 1)
) (
   input  logic [WIDTH-1:0] value,
   input  logic [KW-1:0]    k,
   input  shift_op_e        op,
   output logic [WIDTH-1:0] result
);

`ifdef SHIFT_ROTATE_EN
   localparam int SW = $clog2(WIDTH);
   // k=0 wraps the complementary amount to 0, which still yields value
   logic [SW-1:0] rsh;
   assign rsh = SW'(WIDTH - int'(k));
`endif

   // select shifted value by operation
   always_comb begin
      result = value << k;
      case (op)
         SH_SRL:  result = value >> k;
         SH_SRA:  result = $signed(value) >>> k;
`ifdef SHIFT_ROTATE_EN
         SH_ROL:  result = (value << k) | (value >> rsh);
`endif
         default: result = value << k;
      endcase
   end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle variable shifter with start/busy/done handshake.
// Build option: SHIFT_ROTATE_EN enables op=11 as rotate-left (else SLL).
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_SHIFT | shifting acc by up to STEP bits per cycle, dout not valid
// ST_DONE  | one-cycle done pulse, dout holds result, new start accepted
module shift_unit
   import shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 4,
   localparam int SW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] din,
   input  logic [SW-1:0]    shamt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] dout
);

   localparam int KW = $clog2(STEP + 1);

   shift_state_e     state;
   shift_op_e        op_q;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_nxt;
   logic [SW-1:0]    rem;
   logic [SW-1:0]    rem_nxt;
   logic [KW-1:0]    k;

   // per-cycle amount is the smaller of STEP and what is left
   always_comb begin
      k       = (int'(rem) > STEP) ? KW'(STEP) : KW'(rem);
      rem_nxt = rem - SW'(k);
   end

   shift_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
   ) u_step (
      .value  (acc),
      .k      (k),
      .op     (op_q),
      .result (acc_nxt)
   );

   // handshake FSM and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         acc   <= '0;
         rem   <= '0;
         op_q  <= SH_SLL;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  acc   <= din;
                  rem   <= shamt;
                  op_q  <= shift_op_e'(op);
                  state <= ST_SHIFT;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               acc <= acc_nxt;
               rem <= rem_nxt;
               if (rem_nxt == '0) state <= ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy = (state == ST_SHIFT);
   assign done = (state == ST_DONE);
   assign dout = acc;

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit (WIDTH=32, STEP=4).
module tb_shift_unit;

   localparam int WIDTH = 32;
   localparam int STEP  = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] din;
   logic [4:0]  shamt;
   logic        busy;
   logic        done;
   logic [31:0] dout;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_exp;

   shift_unit #(.WIDTH(WIDTH), .STEP(STEP)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .din   (din),
      .shamt (shamt),
      .busy  (busy),
      .done  (done),
      .dout  (dout)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] d, input int s);
      logic [63:0] dd;
      case (o)
         2'b00:   return d << s;
         2'b01:   return d >> s;
         2'b10:   return $signed(d) >>> s;
         default: begin
`ifdef SHIFT_ROTATE_EN
            dd = {d, d} << s;
            return dd[63:32];
`else
            dd = '0;
            return d << s;
`endif
         end
      endcase
   endfunction

   function automatic int lat_of(input int s);
      return (s == 0) ? 1 : (s + STEP - 1) / STEP;
   endfunction

   // call at #1 after an edge; returns at #1 after the edge that sampled start
   task automatic issue(input logic [1:0] o, input logic [31:0] d, input int s,
                        input logic [31:0] e, input bit push);
      start = 1'b1;
      op    = o;
      din   = d;
      shamt = 5'(s);
      if (push) exp_q.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // waits for done, checking busy, latency and the popped scoreboard entry
   task automatic wait_result(input string name, input int s, input bit inject);
      int cyc = 0;
      int lat = lat_of(s);
      logic [31:0] e;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
      end
      while (cyc < 40) begin
         if (inject) begin
            start = (cyc == 2);
            op    = 2'b00;
            din   = 32'h0000_1234;
            shamt = 5'd1;
         end
         @(posedge clk); #1;
         cyc++;
         if (done) break;
         total++;
         if (busy !== 1'b1) begin
            bad++;
            $display("FAIL %s busy_hold: got %b expected 1 at cycle %0d", name, busy, cyc);
         end
      end
      start = 1'b0;
      if (done !== 1'b1) begin
         total++; bad++;
         $display("FAIL %s timeout: done not seen within %0d cycles", name, cyc);
         return;
      end
      total++;
      if (cyc !== lat) begin
         bad++;
         $display("FAIL %s latency: got %0d expected %0d", name, cyc, lat);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL %s busy_in_done: got %b expected 0", name, busy);
      end
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL %s scoreboard_empty: got done with dout %h, expected nothing", name, dout);
      end else begin
         e = exp_q.pop_front();
         last_exp = e;
         if (dout !== e) begin
            bad++;
            $display("FAIL %s dout: got %h expected %h", name, dout, e);
         end
      end
   endtask

   // one cycle after DONE: done must drop and dout must hold the result
   task automatic idle_check(input string name);
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("FAIL %s double_done: got %b expected 0", name, done);
      end
      total++;
      if (dout !== last_exp) begin
         bad++;
         $display("FAIL %s dout_hold: got %h expected %h", name, dout, last_exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; op = 2'b00; din = '0; shamt = '0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
      total++;
      if (dout !== 32'h0) begin bad++; $display("FAIL reset_dout: got %h expected 00000000", dout); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_sll_legacy();
      issue(2'b00, 32'h0000_0001, 2, 32'h0000_0004, 1'b1);
      wait_result("sll2", 2, 1'b0);
      idle_check("sll2");
   endtask

   task automatic test_sra_srl_max();
      issue(2'b10, 32'h8000_0000, 31, 32'hFFFF_FFFF, 1'b1);
      wait_result("sra31", 31, 1'b0);
      idle_check("sra31");
      issue(2'b01, 32'h8000_0000, 31, 32'h0000_0001, 1'b1);
      wait_result("srl31", 31, 1'b0);
      idle_check("srl31");
   endtask

   task automatic test_zero_shamt();
      issue(2'b01, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b1);
      wait_result("srl0", 0, 1'b0);
      idle_check("srl0");
   endtask

   task automatic test_start_while_busy();
      issue(2'b10, 32'h8000_0000, 31, 32'hFFFF_FFFF, 1'b1);
      wait_result("busy_start", 31, 1'b1);
      idle_check("busy_start");
   endtask

   task automatic test_back_to_back();
      issue(2'b01, 32'hF000_0000, 8, 32'h00F0_0000, 1'b1);
      wait_result("b2b_first", 8, 1'b0);
      issue(2'b00, 32'h0000_0003, 5, 32'h0000_0060, 1'b1);
      wait_result("b2b_second", 5, 1'b0);
      idle_check("b2b_second");
   endtask

   task automatic test_reset_mid();
      bit seen_done = 1'b0;
      issue(2'b00, 32'h0000_0001, 20, 32'h0, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL rst_mid_busy_before: got %b expected 1", busy); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL rst_mid_done: got %b expected 0", done); end
      total++;
      if (dout !== 32'h0) begin bad++; $display("FAIL rst_mid_dout: got %h expected 00000000", dout); end
      repeat (12) begin
         @(posedge clk); #1;
         if (done === 1'b1) seen_done = 1'b1;
      end
      total++;
      if (seen_done) begin bad++; $display("FAIL rst_mid_no_done: got done pulse expected none"); end
   endtask

   task automatic test_rol();
`ifdef SHIFT_ROTATE_EN
      issue(2'b11, 32'h8000_0001, 4, 32'h0000_0018, 1'b1);
`else
      issue(2'b11, 32'h8000_0001, 4, 32'h0000_0010, 1'b1);
`endif
      wait_result("rol4", 4, 1'b0);
      idle_check("rol4");
   endtask

   task automatic test_random();
      for (int i = 0; i < 12; i++) begin
         logic [1:0]  o;
         logic [31:0] d;
         int          s;
         o = 2'($urandom_range(0, 3));
         d = $urandom;
         s = (i < 4) ? 31 : int'($urandom_range(0, 31));
         issue(o, d, s, model(o, d, s), 1'b1);
         wait_result("random", s, 1'b0);
         idle_check("random");
      end
   endtask

   initial begin
      test_reset();
      test_sll_legacy();
      test_sra_srl_max();
      test_zero_shamt();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid();
      test_rol();
      test_random();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
